// File: rtl/lsu_align_unit.sv
// Load/store alignment front-end: splits a byte-addressed access into one or two
// 8-byte-aligned memory beats and merges/extends returned load data.
module lsu_align_unit #(
    parameter int XLEN       = 64,
    parameter int BEAT_BYTES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    input  logic [3:0]            req_size,
    input  logic                  req_sext,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_wen,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [BEAT_BYTES-1:0] mem_wmask,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_B0, S_W0, S_B1, S_W1, S_RESP, S_ERR
    } state_e;

    function automatic logic size_legal(input logic [3:0] size);
        return (size == 4'd1) || (size == 4'd2) || (size == 4'd4) || (size == 4'd8);
    endfunction

    // Byte lanes touched by the access within the low (hi=0) or high (hi=1) beat.
    function automatic logic [7:0] beat_mask(input logic [2:0] off, input logic [3:0] size,
                                             input logic hi);
        logic [7:0]  bm;
        logic [15:0] m16;
        case (size)
            4'd1:    bm = 8'h01;
            4'd2:    bm = 8'h03;
            4'd4:    bm = 8'h0F;
            4'd8:    bm = 8'hFF;
            default: bm = 8'h00;
        endcase
        m16 = {8'h00, bm} << off;
        return hi ? m16[15:8] : m16[7:0];
    endfunction

    function automatic logic [63:0] beat_data(input logic [2:0] off, input logic [63:0] wdata,
                                              input logic hi);
        logic [127:0] w128;
        w128 = {64'h0, wdata} << {off, 3'b000};
        return hi ? w128[127:64] : w128[63:0];
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] rd0, input logic [63:0] rd1,
                                                input logic [2:0] off, input logic [3:0] size,
                                                input logic sext);
        logic [127:0] sh;
        logic [63:0]  d;
        sh = {rd1, rd0} >> {off, 3'b000};
        d  = sh[63:0];
        case (size)
            4'd1:    return sext ? {{56{d[7]}},  d[7:0]}  : {56'h0, d[7:0]};
            4'd2:    return sext ? {{48{d[15]}}, d[15:0]} : {48'h0, d[15:0]};
            4'd4:    return sext ? {{32{d[31]}}, d[31:0]} : {32'h0, d[31:0]};
            default: return d;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [63:0]     addr_q, addr_d, wdata_q, wdata_d, rd0_q, rd0_d;
    logic [3:0]      size_q, size_d;
    logic            wen_q, wen_d, sext_q, sext_d;
    logic            req_ready_q, req_ready_d, mem_valid_q, mem_valid_d, mem_wen_q, mem_wen_d;
    logic [63:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [7:0]      mem_wmask_q, mem_wmask_d;
    logic            resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [63:0]     resp_rdata_q, resp_rdata_d;
    logic            split;
    logic [63:0]     beat1_addr;

    always_comb begin
        // NOTE: every _d starts at its _q so no path through the case can infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        wen_d        = wen_q;
        sext_d       = sext_q;
        rd0_d        = rd0_q;
        req_ready_d  = req_ready_q;
        mem_valid_d  = mem_valid_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        split        = beat_mask(addr_q[2:0], size_q, 1'b1) != 8'h00;
        beat1_addr   = {addr_q[63:3], 3'b000} + 64'd8;

        case (state_q)
            S_IDLE: if (req_valid) begin
                addr_d      = req_addr;
                wdata_d     = req_wdata;
                size_d      = req_size;
                wen_d       = req_wen;
                sext_d      = req_sext;
                req_ready_d = 1'b0;
                if (!size_legal(req_size)) begin
                    state_d      = S_ERR;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 64'h0;
                end else begin
                    state_d     = S_B0;
                    mem_valid_d = 1'b1;
                    mem_wen_d   = req_wen;
                    mem_addr_d  = {req_addr[63:3], 3'b000};
                    mem_wmask_d = beat_mask(req_addr[2:0], req_size, 1'b0);
                    mem_wdata_d = beat_data(req_addr[2:0], req_wdata, 1'b0);
                end
            end
            S_B0: if (mem_ready) begin
                if (!wen_q) begin
                    state_d     = S_W0;
                    mem_valid_d = 1'b0;
                end else if (split) begin
                    state_d     = S_B1;
                    mem_addr_d  = beat1_addr;
                    mem_wmask_d = beat_mask(addr_q[2:0], size_q, 1'b1);
                    mem_wdata_d = beat_data(addr_q[2:0], wdata_q, 1'b1);
                end else begin
                    state_d      = S_RESP;
                    mem_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 64'h0;
                end
            end
            S_W0: if (mem_rvalid) begin
                rd0_d = mem_rdata;
                if (split) begin
                    state_d     = S_B1;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = beat1_addr;
                    mem_wmask_d = beat_mask(addr_q[2:0], size_q, 1'b1);
                    mem_wdata_d = beat_data(addr_q[2:0], wdata_q, 1'b1);
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extend(mem_rdata, 64'h0, addr_q[2:0], size_q, sext_q);
                end
            end
            S_B1: if (mem_ready) begin
                mem_valid_d = 1'b0;
                if (wen_q) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 64'h0;
                end else begin
                    state_d = S_W1;
                end
            end
            S_W1: if (mem_rvalid) begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_extend(rd0_q, mem_rdata, addr_q[2:0], size_q, sext_q);
            end
            S_RESP, S_ERR: if (resp_ready) begin
                state_d      = S_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = 64'h0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            wen_q        <= 1'b0;
            sext_q       <= 1'b0;
            rd0_q        <= '0;
            req_ready_q  <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge _d values together.
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            wen_q        <= wen_d;
            sext_q       <= sext_d;
            rd0_q        <= rd0_d;
            req_ready_q  <= req_ready_d;
            mem_valid_q  <= mem_valid_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_valid  = mem_valid_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
